// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave
//   AHB-Lite slave backed by a word-organised on-chip SRAM. Each address
//   phase is registered, the data phase runs with WAIT_STATES
//   HREADYOUT-low cycles, and byte/halfword/word writes use
//   little-endian byte enables. Illegal transfers (bad size, misaligned,
//   out of range) get the two-cycle ERROR response and never reach memory.
//
// Parameters
//   ADDR_WIDTH   word-address bits; depth = 2**ADDR_WIDTH 32-bit words
//   WAIT_STATES  HREADYOUT-low cycles per OKAY data phase (0..7)
//
// Ports
//   HCLK       in   bus clock, rising edge
//   HRESETn    in   asynchronous active-low reset
//   HSEL       in   slave select
//   HADDR      in   [31:0] byte address
//   HWDATA     in   [31:0] write data (data phase)
//   HRDATA     out  [31:0] read data, non-zero only in final read data-phase cycle
//   HWRITE     in   1 = write, 0 = read
//   HSIZE      in   [2:0] 0 byte, 1 halfword, 2 word, >2 illegal
//   HBURST     in   [2:0] ignored
//   HPROT      in   [3:0] ignored
//   HTRANS     in   [1:0] IDLE/BUSY/NONSEQ/SEQ
//   HREADYOUT  out  data phase completes this cycle
//   HREADY     in   bus-wide ready; address phase sampled only when 1
//   HRESP      out  0 OKAY, 1 ERROR
module ahb_lite_sram_slave #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [1:0]  HTRANS,
  output logic        HREADYOUT,
  input  logic        HREADY,
  output logic        HRESP
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [2:0]  WS    = 3'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic                    active_q, active_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [1:0]              boff_q, boff_d;
  logic [1:0]              size_q, size_d;
  logic                    write_q, write_d;

  logic [31:0]             mem_q [DEPTH];

  logic                    valid;
  logic                    can_sample;
  logic                    size_err;
  logic                    align_err;
  logic                    range_err;
  logic                    xfer_err;
  logic                    complete;
  logic [3:0]              be;

  // Burst type and protection are accepted but carry no meaning here.
  logic                    unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

  // ---------------------------------------------------------------------
  // Address-phase decode
  // ---------------------------------------------------------------------
  assign valid      = HSEL & HREADY & HTRANS[1];
  assign can_sample = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2);

  assign size_err   = (HSIZE > 3'd2);
  assign align_err  = ((HSIZE == 3'd1) && HADDR[0]) ||
                      ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
  // Any address bit above the SRAM's byte range is an error, never aliased.
  assign range_err  = ((HADDR >> (ADDR_WIDTH + 2)) != '0);
  assign xfer_err   = size_err | align_err | range_err;

  // Final OKAY data-phase cycle: DONE after wait states, or IDLE with a
  // zero-wait transfer pending.
  assign complete   = (state_q == S_DONE) || ((state_q == S_IDLE) && active_q);

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = 1'b0;
    waddr_d  = waddr_q;
    boff_d   = boff_q;
    size_d   = size_q;
    write_d  = write_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR2: begin
        state_d = S_IDLE;
        if (can_sample && valid) begin
          if (xfer_err) begin
            state_d = S_ERR1;
          end else begin
            waddr_d = HADDR[ADDR_WIDTH+1:2];
            boff_d  = HADDR[1:0];
            size_d  = HSIZE[1:0];
            write_d = HWRITE;
            if (WAIT_STATES != 0) begin
              state_d = S_WAIT;
              cnt_d   = WS;
            end else begin
              active_d = 1'b1;
            end
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = S_DONE;
        end
      end
      S_ERR1: begin
        state_d = S_ERR2;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      active_q <= 1'b0;
      waddr_q  <= '0;
      boff_q   <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      waddr_q  <= waddr_d;
      boff_q   <= boff_d;
      size_q   <= size_d;
      write_q  <= write_d;
    end
  end

  // ---------------------------------------------------------------------
  // Byte enables (little-endian lanes)
  // ---------------------------------------------------------------------
  always_comb begin
    be = '0;
    unique case (size_q)
      2'd0: be[boff_q] = 1'b1;
      2'd1: begin
        be[{boff_q[1], 1'b0}] = 1'b1;
        be[{boff_q[1], 1'b1}] = 1'b1;
      end
      default: be = '1;
    endcase
  end

  // ---------------------------------------------------------------------
  // SRAM: not reset. The write gate depends on state that resets
  // asynchronously, so a pending write is dropped by reset.
  // ---------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (complete && write_q) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[waddr_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
  assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
  // Read is combinational from the array so a write committed at the
  // previous edge is visible to an immediately following read.
  assign HRDATA    = (complete && !write_q) ? mem_q[waddr_q] : '0;

endmodule
